// File: rtl/debounce_pkg.sv
// Shared types and constants for the debounce input conditioner.
package debounce_pkg;

  typedef enum logic [1:0] {
    LOW,
    RISING,
    HIGH,
    FALLING
  } debounce_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/sync_2ff.sv
// Flop-chain synchronizer for bringing an asynchronous level into the clk domain.
module sync_2ff
  import debounce_pkg::*;
(
  input  logic clk,
  input  logic i_reset,
  input  logic i_x,
  output logic o_x
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_x};
    end
  end

  assign o_x = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce.sv
// Debounces i_x into a clean level o_x with one-cycle rise/fall strobes.
// Define DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer ahead of the FSM.
module debounce
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 8,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_x,
  output logic o_x,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit               SINGLE   = (STABLE_CYCLES == 1);

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk    (clk),
    .i_reset(i_reset),
    .i_x    (i_x),
    .o_x    (s)
  );
`else
  assign s = i_x;
`endif

  debounce_state_t  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             x_q;
  logic             rise_q;
  logic             fall_q;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        LOW: begin
          if (s) begin
            if (SINGLE) begin
              state_q <= HIGH;
              x_q     <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              state_q <= RISING;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        RISING: begin
          if (s) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= HIGH;
              cnt_q   <= '0;
              x_q     <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end else begin
            // any disagreeing sample discards the partial count
            state_q <= LOW;
            cnt_q   <= '0;
          end
        end
        HIGH: begin
          if (!s) begin
            if (SINGLE) begin
              state_q <= LOW;
              x_q     <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              state_q <= FALLING;
              cnt_q   <= CNT_ONE;
            end
          end
        end
        FALLING: begin
          if (!s) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= LOW;
              cnt_q   <= '0;
              x_q     <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end else begin
            state_q <= HIGH;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= LOW;
          cnt_q   <= '0;
          x_q     <= 1'b0;
        end
      endcase
    end
  end

  assign o_x    = x_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      assert (!(rise_q && fall_q));
      assert (cnt_q <= CNT_LAST);
    end
  end
`endif

endmodule

// File: tb/tb_debounce.sv
// Directed bench for debounce: per-cycle vector table plus latency sequences.
module tb_debounce;

  localparam int unsigned SC = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, x, ox, rise, fall;
  logic x1, ox1, rise1, fall1;

  debounce #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .i_reset(rst), .i_x(x), .o_x(ox), .o_rise(rise), .o_fall(fall)
  );

  debounce #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .i_reset(rst), .i_x(x1), .o_x(ox1), .o_rise(rise1), .o_fall(fall1)
  );

  // {rst, x, expected o_x, expected o_rise, expected o_fall}, one cycle each
  typedef struct packed {
    logic rst;
    logic x;
    logic ox;
    logic rise;
    logic fall;
  } vec_t;

  vec_t tbl[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    x   = 1'b1;
    x1  = 1'b0;
    tick();
    tick();
    check("reset_ox", 0, ox, 1'b0);
    check("reset_rise", 0, rise, 1'b0);
    check("reset_fall", 0, fall, 1'b0);
    check("reset_ox1", 0, ox1, 1'b0);
    check("reset_rise1", 0, rise1, 1'b0);
    check("reset_fall1", 0, fall1, 1'b0);

`ifndef DEBOUNCE_SYNC_EN
    tbl = '{
      5'b11_000, 5'b01_000, 5'b01_000, 5'b01_000, 5'b01_110, 5'b01_100, 5'b01_100,
      5'b00_100, 5'b00_100, 5'b01_100, 5'b00_100, 5'b00_100, 5'b00_100, 5'b00_001,
      5'b00_000,
      5'b01_000, 5'b01_000, 5'b01_000, 5'b00_000, 5'b01_000, 5'b01_000, 5'b01_000,
      5'b00_000,
      5'b01_000, 5'b01_000, 5'b01_000, 5'b01_110, 5'b00_100, 5'b00_100, 5'b10_000,
      5'b00_000, 5'b00_000,
      5'b01_000, 5'b01_000, 5'b01_000, 5'b01_110, 5'b11_000, 5'b01_000, 5'b01_000,
      5'b01_000, 5'b01_110,
      5'b00_100, 5'b00_100, 5'b00_100, 5'b00_001, 5'b01_000, 5'b01_000, 5'b01_000,
      5'b01_110,
      5'b00_100, 5'b01_100, 5'b00_100, 5'b01_100
    };
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      x   = tbl[i].x;
      tick();
      check("tbl_ox", i, ox, tbl[i].ox);
      check("tbl_rise", i, rise, tbl[i].rise);
      check("tbl_fall", i, fall, tbl[i].fall);
    end
`endif

    // clean rise latency, including synchronizer delay when present
    rst = 1'b1;
    x   = 1'b0;
    x1  = 1'b0;
    tick();
    rst = 1'b0;
    x   = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      check("lat_ox", j, ox, (j >= int'(SC) + SYNC_LAT));
      check("lat_rise", j, rise, (j == int'(SC) + SYNC_LAT));
      check("lat_fall", j, fall, 1'b0);
    end

    // STABLE_CYCLES=1: single-cycle input high passes through one cycle later
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      x1 = (j == 1);
      tick();
      check("sc1_ox", j, ox1, (j == 1 + SYNC_LAT));
      check("sc1_rise", j, rise1, (j == 1 + SYNC_LAT));
      check("sc1_fall", j, fall1, (j == 2 + SYNC_LAT));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce.md
# debounce

Input conditioner that sits directly upstream of `pulse`. It filters a noisy or asynchronous level `i_x` (button, external strobe) into a clean, glitch-free level `o_x` that can drive the `pulse` block's `i_x`. It also produces single-cycle edge strobes. A new output level is accepted only after the input has held that level for `STABLE_CYCLES` consecutive clock edges.

## Interface
- `STABLE_CYCLES`, default 8: consecutive agreeing samples required to change `o_x`; legal range 1..65535.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: counter width. Derived; do not override.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `i_reset`  input  1  synchronous, active-high reset.
- `i_x`  input  1  raw level, possibly bouncing or asynchronous.
- `o_x`  output  1  debounced level, registered.
- `o_rise`  output  1  one-cycle strobe, high in the same cycle `o_x` first reads 1.
- `o_fall`  output  1  one-cycle strobe, high in the same cycle `o_x` first reads 0.

## Operation
- `s` is the sampled input: `i_x`, or the synchronizer output when `DEBOUNCE_SYNC_EN` is defined.
- FSM states:
  - `LOW`: stable 0.
  - `RISING`: counting 1s.
  - `HIGH`: stable 1.
  - `FALLING`: counting 0s.
- Counter `cnt` (`CNT_W` bits) is nonzero only in `RISING`/`FALLING`.
- `LOW`, `s`=1: if `STABLE_CYCLES`==1, go to `HIGH` with `o_x`<=1 and `o_rise`<=1. Otherwise go to `RISING` with `cnt`<=1.
- `RISING`, `s`=1: if `cnt`==`STABLE_CYCLES`-1, go to `HIGH` with `o_x`<=1, `o_rise`<=1, `cnt`<=0. Otherwise `cnt`<=`cnt`+1.
- `RISING`, `s`=0: return to `LOW`, `cnt`<=0. A glitch fully restarts qualification; there is no partial credit.
- `HIGH`/`FALLING`: mirror of `LOW`/`RISING` with the polarity inverted; uses `o_fall`.
- `o_x` is 0 in `LOW`/`RISING` and 1 in `HIGH`/`FALLING`. It changes only on a qualified transition.
- Strobes are high for exactly one cycle and are never both high. Each strobe is registered in the same edge that updates `o_x`.
- The counter never exceeds `STABLE_CYCLES`-1. No wrap-around is possible.

## Timing
- Reset (sampled `i_reset`=1 at an edge): state `LOW`, `cnt`=0, `o_x`=0, `o_rise`=0, `o_fall`=0, synchronizer flops=0.
- Reset applied mid-count or while `HIGH` aborts immediately. `o_x` returns to 0 without asserting `o_fall`.
- `i_reset` has priority over all input activity in the same cycle.
- Latency without sync: `s` first samples 1 at edge k and stays 1. Then `o_x`=1 and `o_rise`=1 after edge k+`STABLE_CYCLES`-1. For `STABLE_CYCLES`=1 this is after edge k.
- Latency with sync: add exactly 2 cycles.
- An input toggling every cycle never changes `o_x` for any `STABLE_CYCLES`>=2.
- A transition becomes qualified at the same edge that `s` changes back: the qualifying edge wins. The new level is accepted, and the reversal starts a fresh count in the opposite direction on the next edge.

## Configuration
- `DEBOUNCE_SYNC_EN` defined: `i_x` passes through a 2-flop synchronizer before the FSM. Use this for asynchronous pins. Adds 2 cycles of latency.
- `DEBOUNCE_SYNC_EN` undefined: `i_x` feeds the FSM directly. The caller guarantees `i_x` is synchronous to `clk`.

## Structure
- Package `debounce_pkg`: state enum `debounce_state_t` (`LOW`, `RISING`, `HIGH`, `FALLING`) and a `SYNC_STAGES`=2 constant.
- Sub-module `sync_2ff` (`clk`, `i_reset`, `i_x`, `o_x`): instantiated only under `DEBOUNCE_SYNC_EN`, and reusable elsewhere.
- FSM, counter and strobe registers live in `debounce`.

## Test plan
All scenarios use `STABLE_CYCLES`=4 with the macro undefined, unless stated.
- Reset: pulse `i_reset` for 1 cycle with `i_x`=1 held. Then `o_x`=0, `o_rise`=0, `o_fall`=0, and `o_x` stays 0 until 4 qualifying edges after reset release.
- Clean rise: `i_x` 0→1, held 10 cycles. `o_x` rises after the 4th edge sampling 1, and `o_rise` is high for exactly that cycle.
- Bounce: `i_x` = 1,1,1,0,1,1,1,0 repeated. `o_x` stays 0 and neither strobe fires.
- Clean fall, reset mid-count:
  - From `o_x`=1, drive `i_x`=0 for 4 cycles: `o_fall` fires once and `o_x`=0.
  - Repeat, but assert `i_reset` after 2 zero samples: `o_x`=0, and no `o_fall` pulse appears.
- `STABLE_CYCLES`=1 with `debounce` driving `pulse` (`WIDTH`=4): a 1-cycle `i_x` high gives `o_x` high for 1 cycle, delayed 1 cycle, and `pulse.o_x` high for 4 cycles.
- With `DEBOUNCE_SYNC_EN` defined: the clean-rise scenario gives `o_rise` exactly 2 cycles later than in the undefined build.
